// File: rtl/eco32f_dbus_ctrl.sv
// eco32f_dbus_ctrl -- data-side bus controller for the eco32f core.
//
// Owns the Wishbone data master port. Services three kinds of traffic:
//   * cache-line refills on a cached load miss (critical-word-first, wrapping
//     burst, each beat written into the cache through cache_wr_*)
//   * single-beat uncached loads (req_addr[31:28] == UNC_NIBBLE)
//   * posted stores, queued in a small FIFO and drained one beat at a time
//
// Optional feature (macro ECO32F_DBUS_SB_BYPASS_EN):
//   defined   - a load may go ahead of pending stores unless a buffered
//               entry matches req_addr[31:2]; on a match the buffer drains
//               until the match is gone.
//   undefined - a load leaves IDLE only once the store buffer is empty; no
//               address comparators are built.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_load, req_store      load / store request, held until req_ack
//   req_addr, req_sel        physical address, byte lanes (bit3 = byte 0)
//   req_wdata, req_miss      store data, cache miss for the current load
//   req_ack, rd_data         one-cycle completion pulse, load word
//   sb_full, sb_empty        store buffer status
//   bus_err                  one-cycle pulse on an err_i termination
//   cache_wr_*               refill write port into the data cache
//   dwbm_*                   Wishbone B3 master (registered feedback bursts)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no bus cycle; picks load / drain / nothing when req_ack is low
// REFILL   | wrapping line burst in flight, then one cycle to raise req_ack
// UNC_READ | single uncached read beat in flight
// DRAIN    | single write beat of the oldest store buffer entry in flight

module eco32f_dbus_ctrl #(
    parameter int          LINE_WORDS = 8,
    parameter int          SB_DEPTH   = 4,
    parameter logic [3:0]  UNC_NIBBLE = 4'hf
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_wdata,
    input  logic        req_miss,
    output logic        req_ack,
    output logic [31:0] rd_data,
    output logic        sb_full,
    output logic        sb_empty,
    output logic        bus_err,
    output logic        cache_wr_en,
    output logic [31:0] cache_wr_addr,
    output logic [31:0] cache_wr_data,
    output logic [31:0] dwbm_adr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_stb_o,
    output logic        dwbm_cyc_o,
    output logic [2:0]  dwbm_cti_o,
    output logic [1:0]  dwbm_bte_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i
);

    localparam int         BW        = $clog2(LINE_WORDS);
    localparam int         PW        = $clog2(SB_DEPTH);
    localparam logic [1:0] BTE_LINE  = (LINE_WORDS == 4) ? 2'b01 :
                                       (LINE_WORDS == 8) ? 2'b10 : 2'b11;
    localparam logic [31:0] LINE_MASK = 32'((LINE_WORDS - 1) * 4);
    localparam logic [2:0] CTI_INCR  = 3'b010;
    localparam logic [2:0] CTI_END   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_UNC_READ,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   sb_addr [SB_DEPTH];
    logic [31:0]   sb_data [SB_DEPTH];
    logic [3:0]    sb_sel  [SB_DEPTH];
    logic [PW-1:0] sb_head, sb_tail;
    logic [PW:0]   sb_count;

    logic [BW-1:0] beat_cnt;
    logic          refill_done;

    logic unc_hit, load_elig, load_go, bus_term;
    logic push, pop, start_refill, start_unc, start_drain;

    assign sb_full   = (sb_count == (PW+1)'(SB_DEPTH));
    assign sb_empty  = (sb_count == '0);
    assign unc_hit   = (req_addr[31:28] == UNC_NIBBLE);
    // Cached hits are served by the cache itself; only misses and uncached
    // loads need the bus.
    assign load_elig = req_load & (unc_hit | req_miss);
    assign bus_term  = dwbm_cyc_o & dwbm_stb_o & (dwbm_ack_i | dwbm_err_i);

`ifdef ECO32F_DBUS_SB_BYPASS_EN
    logic [SB_DEPTH-1:0] sb_valid;
    logic                sb_hit;

    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] && (sb_addr[i][31:2] == req_addr[31:2]))
                sb_hit = 1'b1;
        end
    end

    assign load_go = load_elig & ~sb_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
        end else begin
            if (push)
                sb_valid[sb_tail] <= 1'b1;
            if (pop)
                sb_valid[sb_head] <= 1'b0;
        end
    end
`else
    assign load_go = load_elig & sb_empty;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        start_refill = 1'b0;
        start_unc    = 1'b0;
        start_drain  = 1'b0;
        pop          = 1'b0;
        // Stores are also accepted while a drain beat is stalled on the bus,
        // so the buffer can actually fill behind a slow slave.
        push = req_store & ~sb_full & ~req_ack &
               ((state == S_IDLE) | (state == S_DRAIN));
        case (state)
            S_IDLE: begin
                if (!req_ack) begin
                    if (load_go) begin
                        if (unc_hit) begin
                            start_unc = 1'b1;
                            state_nxt = S_UNC_READ;
                        end else begin
                            start_refill = 1'b1;
                            state_nxt    = S_REFILL;
                        end
                    end else if (!sb_empty) begin
                        start_drain = 1'b1;
                        state_nxt   = S_DRAIN;
                    end
                end
            end
            S_REFILL: begin
                if (refill_done)
                    state_nxt = S_IDLE;
            end
            S_UNC_READ: begin
                if (bus_term)
                    state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (bus_term) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[sb_tail] <= req_addr;
            sb_data[sb_tail] <= req_wdata;
            sb_sel[sb_tail]  <= req_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwbm_adr_o    <= '0;
            dwbm_dat_o    <= '0;
            dwbm_sel_o    <= '0;
            dwbm_we_o     <= 1'b0;
            dwbm_stb_o    <= 1'b0;
            dwbm_cyc_o    <= 1'b0;
            dwbm_cti_o    <= CTI_END;
            dwbm_bte_o    <= 2'b00;
            req_ack       <= 1'b0;
            rd_data       <= '0;
            bus_err       <= 1'b0;
            cache_wr_en   <= 1'b0;
            cache_wr_addr <= '0;
            cache_wr_data <= '0;
            beat_cnt      <= '0;
            refill_done   <= 1'b0;
            sb_head       <= '0;
            sb_tail       <= '0;
            sb_count      <= '0;
        end else begin
            req_ack     <= push;
            bus_err     <= 1'b0;
            cache_wr_en <= 1'b0;

            if (start_refill) begin
                dwbm_adr_o  <= {req_addr[31:2], 2'b00};
                dwbm_sel_o  <= 4'b1111;
                dwbm_we_o   <= 1'b0;
                dwbm_stb_o  <= 1'b1;
                dwbm_cyc_o  <= 1'b1;
                dwbm_cti_o  <= CTI_INCR;
                dwbm_bte_o  <= BTE_LINE;
                beat_cnt    <= '0;
                refill_done <= 1'b0;
            end
            if (start_unc) begin
                dwbm_adr_o <= req_addr;
                dwbm_sel_o <= req_sel;
                dwbm_we_o  <= 1'b0;
                dwbm_stb_o <= 1'b1;
                dwbm_cyc_o <= 1'b1;
                dwbm_cti_o <= CTI_END;
                dwbm_bte_o <= 2'b00;
            end
            if (start_drain) begin
                dwbm_adr_o <= sb_addr[sb_head];
                dwbm_dat_o <= sb_data[sb_head];
                dwbm_sel_o <= sb_sel[sb_head];
                dwbm_we_o  <= 1'b1;
                dwbm_stb_o <= 1'b1;
                dwbm_cyc_o <= 1'b1;
                dwbm_cti_o <= CTI_END;
                dwbm_bte_o <= 2'b00;
            end

            case (state)
                S_REFILL: begin
                    // refill_done gives the extra cycle between the last
                    // cache write and req_ack.
                    if (refill_done) begin
                        req_ack     <= 1'b1;
                        refill_done <= 1'b0;
                    end else if (bus_term) begin
                        if (dwbm_err_i) begin
                            bus_err     <= 1'b1;
                            dwbm_stb_o  <= 1'b0;
                            dwbm_cyc_o  <= 1'b0;
                            dwbm_cti_o  <= CTI_END;
                            refill_done <= 1'b1;
                        end else begin
                            cache_wr_en   <= 1'b1;
                            cache_wr_addr <= dwbm_adr_o;
                            cache_wr_data <= dwbm_dat_i;
                            if (beat_cnt == '0)
                                rd_data <= dwbm_dat_i;
                            if (beat_cnt == BW'(LINE_WORDS - 1)) begin
                                dwbm_stb_o  <= 1'b0;
                                dwbm_cyc_o  <= 1'b0;
                                dwbm_cti_o  <= CTI_END;
                                refill_done <= 1'b1;
                            end else begin
                                // Only the word index inside the line
                                // advances; upper bits stay on the line.
                                dwbm_adr_o <= (dwbm_adr_o & ~LINE_MASK) |
                                              ((dwbm_adr_o + 32'd4) & LINE_MASK);
                                beat_cnt   <= beat_cnt + BW'(1);
                                dwbm_cti_o <= (beat_cnt == BW'(LINE_WORDS - 2)) ?
                                              CTI_END : CTI_INCR;
                            end
                        end
                    end
                end
                S_UNC_READ: begin
                    if (bus_term) begin
                        dwbm_stb_o <= 1'b0;
                        dwbm_cyc_o <= 1'b0;
                        req_ack    <= 1'b1;
                        if (dwbm_err_i)
                            bus_err <= 1'b1;
                        else
                            rd_data <= dwbm_dat_i;
                    end
                end
                S_DRAIN: begin
                    if (bus_term) begin
                        dwbm_stb_o <= 1'b0;
                        dwbm_cyc_o <= 1'b0;
                        dwbm_we_o  <= 1'b0;
                        if (dwbm_err_i)
                            bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (push)
                sb_tail <= sb_tail + PW'(1);
            if (pop)
                sb_head <= sb_head + PW'(1);
            case ({push, pop})
                2'b10:   sb_count <= sb_count + (PW+1)'(1);
                2'b01:   sb_count <= sb_count - (PW+1)'(1);
                default: sb_count <= sb_count;
            endcase
        end
    end

endmodule

// File: tb/tb_eco32f_dbus_ctrl.sv
// Bench for eco32f_dbus_ctrl: a Wishbone slave model answers bus beats with
// data derived from the address; expected bus beats and cache writes are
// queued when stimulus is issued and compared as the DUT produces them.
module tb_eco32f_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_load = 1'b0, req_store = 1'b0, req_miss = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_sel = '0;
    logic        req_ack, sb_full, sb_empty, bus_err, cache_wr_en;
    logic [31:0] rd_data, cache_wr_addr, cache_wr_data;
    logic [31:0] dwbm_adr_o, dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o, dwbm_stb_o, dwbm_cyc_o;
    logic [2:0]  dwbm_cti_o;
    logic [1:0]  dwbm_bte_o;
    logic [31:0] dwbm_dat_i = '0;
    logic        dwbm_ack_i = 1'b0, dwbm_err_i = 1'b0;

    always #5 clk = ~clk;

    eco32f_dbus_ctrl dut (
        .clk(clk), .rst(rst),
        .req_load(req_load), .req_store(req_store), .req_addr(req_addr),
        .req_sel(req_sel), .req_wdata(req_wdata), .req_miss(req_miss),
        .req_ack(req_ack), .rd_data(rd_data),
        .sb_full(sb_full), .sb_empty(sb_empty), .bus_err(bus_err),
        .cache_wr_en(cache_wr_en), .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data),
        .dwbm_adr_o(dwbm_adr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
        .dwbm_we_o(dwbm_we_o), .dwbm_stb_o(dwbm_stb_o), .dwbm_cyc_o(dwbm_cyc_o),
        .dwbm_cti_o(dwbm_cti_o), .dwbm_bte_o(dwbm_bte_o),
        .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } beat_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } cw_t;

    beat_t bus_q[$];
    cw_t   cw_q[$];

    int n_tests = 0, n_fail = 0;
    int cyc_cnt = 0, n_cw = 0, n_err = 0, n_rack = 0;
    int last_cw_cyc = 0, last_beat_cyc = 0;
    logic        hold_ack = 1'b0;
    logic        err_armed = 1'b0;
    logic [31:0] err_adr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hF000_0004)
            return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    always @(posedge clk) cyc_cnt++;

    // Slave model and monitors: decide and check on the falling edge so the
    // DUT sees ack/err at the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        cw_t   c;
        dwbm_ack_i = 1'b0;
        dwbm_err_i = 1'b0;
        if (!rst && dwbm_cyc_o && dwbm_stb_o && !hold_ack) begin
            check("bus_beat_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) begin
                e = bus_q.pop_front();
                check("bus_adr", dwbm_adr_o, e.adr);
                check("bus_ctl", 32'({dwbm_we_o, dwbm_sel_o, dwbm_cti_o, dwbm_bte_o}),
                      32'({e.we, e.sel, e.cti, e.bte}));
                if (e.we)
                    check("bus_wdat", dwbm_dat_o, e.dat);
            end
            if (err_armed && dwbm_adr_o == err_adr) begin
                dwbm_err_i = 1'b1;
                err_armed  = 1'b0;
            end else begin
                dwbm_ack_i = 1'b1;
            end
            dwbm_dat_i    = mem_word(dwbm_adr_o);
            last_beat_cyc = cyc_cnt;
        end
        if (!rst && cache_wr_en) begin
            n_cw++;
            last_cw_cyc = cyc_cnt;
            check("cw_expected", 32'(cw_q.size() != 0), 32'd1);
            if (cw_q.size() != 0) begin
                c = cw_q.pop_front();
                check("cw_adr", cache_wr_addr, c.adr);
                check("cw_dat", cache_wr_data, c.dat);
            end
        end
        if (!rst && bus_err) n_err++;
        if (!rst && req_ack) n_rack++;
    end

    function automatic beat_t mk_beat(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input logic w,
                                      input logic [2:0] ct, input logic [1:0] bt);
        beat_t b;
        b.adr = a; b.dat = d; b.sel = s; b.we = w; b.cti = ct; b.bte = bt;
        return b;
    endfunction

    // Wrapping 8-word line, critical word first; ncw cache writes expected.
    task automatic push_refill(input logic [31:0] a, input int nbeats, input int ncw);
        logic [31:0] ba;
        cw_t c;
        for (int i = 0; i < nbeats; i++) begin
            ba = (a & ~32'h1F) | ((a + 32'(4 * i)) & 32'h1C);
            bus_q.push_back(mk_beat(ba, 32'h0, 4'hF, 1'b0,
                                    (i == 7) ? 3'b111 : 3'b010, 2'b10));
            if (i < ncw) begin
                c.adr = ba;
                c.dat = mem_word(ba);
                cw_q.push_back(c);
            end
        end
    endtask

    task automatic wait_ack(input string tag, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (req_ack) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_empty(input string tag, input int budget);
        logic got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk); #1;
            if (sb_empty && !dwbm_cyc_o) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d, input logic expect_beat);
        if (expect_beat)
            bus_q.push_back(mk_beat(a, d, s, 1'b1, 3'b111, 2'b00));
        req_addr = a; req_sel = s; req_wdata = d; req_store = 1'b1;
        wait_ack("store_ack", 40);
        req_store = 1'b0;
    endtask

    task automatic start_load(input logic [31:0] a, input logic [3:0] s,
                              input logic miss, input logic expect_refill);
        if (a[31:28] == 4'hF)
            bus_q.push_back(mk_beat(a, 32'h0, s, 1'b0, 3'b111, 2'b00));
        else if (expect_refill)
            push_refill(a, 8, 8);
        req_addr = a; req_sel = s; req_miss = miss; req_load = 1'b1;
    endtask

    task automatic finish_load(input string tag, input logic [31:0] exp_data,
                               input int gap_mode);
        wait_ack({tag, "_ack"}, 80);
        check({tag, "_rd"}, rd_data, exp_data);
        if (gap_mode == 1) check({tag, "_gap_beat"}, 32'(cyc_cnt - last_beat_cyc), 32'd1);
        if (gap_mode == 2) check({tag, "_gap_cw"}, 32'(cyc_cnt - last_cw_cyc), 32'd1);
        req_load = 1'b0;
        req_miss = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  c0, r0, e0;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sb_empty", 32'(sb_empty), 32'd1);
        check("rst_sb_full", 32'(sb_full), 32'd0);
        check("rst_cyc_stb_we", 32'({dwbm_cyc_o, dwbm_stb_o, dwbm_we_o}), 32'd0);
        check("rst_cwen_ack_err", 32'({cache_wr_en, req_ack, bus_err}), 32'd0);
        check("rst_cti", 32'(dwbm_cti_o), 32'd7);
        check("rst_rd_data", rd_data, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Refill with critical word first and wrap.
        c0 = n_cw; r0 = n_rack;
        start_load(32'h0000_0014, 4'hF, 1'b1, 1'b1);
        finish_load("refill", mem_word(32'h0000_0014), 2);
        repeat (2) @(posedge clk); #1;
        check("refill_cw_cnt", 32'(n_cw - c0), 32'd8);
        check("refill_ack_cnt", 32'(n_rack - r0), 32'd1);

        // Uncached single beat.
        c0 = n_cw;
        start_load(32'hF000_0004, 4'b0011, 1'b0, 1'b0);
        finish_load("unc", 32'h1234_5678, 1);
        repeat (2) @(posedge clk); #1;
        check("unc_cw_cnt", 32'(n_cw - c0), 32'd0);

        // Cached hit: nothing happens on the bus.
        r0 = n_rack;
        req_addr = 32'h0000_0040; req_miss = 1'b0; req_load = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("hit_no_cyc", 32'(dwbm_cyc_o), 32'd0);
        req_load = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("hit_no_ack", 32'(n_rack - r0), 32'd0);

        // Fill the store buffer behind a stalled slave.
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++)
            do_store(32'h0000_0100 + 32'(4 * i), 4'(i + 1), 32'hA000_0000 + 32'(i), 1'b1);
        @(posedge clk); #1;
        check("sb_full_after4", 32'(sb_full), 32'd1);
        bus_q.push_back(mk_beat(32'h0000_0110, 32'hA000_0004, 4'h9, 1'b1, 3'b111, 2'b00));
        req_addr = 32'h0000_0110; req_sel = 4'h9; req_wdata = 32'hA000_0004; req_store = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (req_ack) seen = 1'b1;
        end
        check("st5_stalled", 32'(seen), 32'd0);
        hold_ack = 1'b0;
        wait_ack("st5_ack", 20);
        req_store = 1'b0;
        wait_empty("sb_drained", 100);

        // Load behind buffered stores.
        hold_ack = 1'b1;
        do_store(32'h0000_0180, 4'hF, 32'hB000_0000, 1'b1);
`ifdef ECO32F_DBUS_SB_BYPASS_EN
        do_store(32'h0000_0184, 4'hF, 32'hB000_0001, 1'b0);
        start_load(32'h0000_0200, 4'hF, 1'b1, 1'b1);
        bus_q.push_back(mk_beat(32'h0000_0184, 32'hB000_0001, 4'hF, 1'b1, 3'b111, 2'b00));
`else
        do_store(32'h0000_0184, 4'hF, 32'hB000_0001, 1'b1);
        start_load(32'h0000_0200, 4'hF, 1'b1, 1'b1);
`endif
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (req_ack) seen = 1'b1;
        end
        check("ld_wait_no_ack", 32'(seen), 32'd0);
        check("ld_wait_sb_nonempty", 32'(sb_empty), 32'd0);
        hold_ack = 1'b0;
        finish_load("ld_after_st", mem_word(32'h0000_0200), 2);
        wait_empty("ld_after_st_empty", 60);

        // Error on third refill beat.
        c0 = n_cw; r0 = n_rack; e0 = n_err;
        err_adr = 32'h0000_0048; err_armed = 1'b1;
        push_refill(32'h0000_0040, 3, 2);
        start_load(32'h0000_0040, 4'hF, 1'b1, 1'b0);
        finish_load("rf_err", mem_word(32'h0000_0040), 0);
        repeat (2) @(posedge clk); #1;
        check("rf_err_cw_cnt", 32'(n_cw - c0), 32'd2);
        check("rf_err_buserr", 32'(n_err - e0), 32'd1);
        check("rf_err_ack_cnt", 32'(n_rack - r0), 32'd1);
        check("rf_err_idle", 32'(dwbm_cyc_o), 32'd0);

        // Errored store is dropped.
        e0 = n_err;
        err_adr = 32'h0000_0300; err_armed = 1'b1;
        do_store(32'h0000_0300, 4'hC, 32'hC0C0_0300, 1'b1);
        wait_empty("st_err_empty", 40);
        repeat (2) @(posedge clk); #1;
        check("st_err_buserr", 32'(n_err - e0), 32'd1);

        // Reset mid-refill.
        c0 = n_cw;
        start_load(32'h0000_0080, 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 40 && (n_cw - c0) < 3; i++) begin
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b1;
        req_load = 1'b0;
        #1;
        check("rst_mid_rf_cyc_stb", 32'({dwbm_cyc_o, dwbm_stb_o}), 32'd0);
        check("rst_mid_rf_empty", 32'(sb_empty), 32'd1);
        bus_q.delete(); cw_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-drain loses buffered stores.
        hold_ack = 1'b1;
        do_store(32'h0000_0400, 4'hF, 32'hD000_0000, 1'b1);
        do_store(32'h0000_0404, 4'hF, 32'hD000_0001, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_dr_cyc", 32'(dwbm_cyc_o), 32'd0);
        check("rst_mid_dr_empty", 32'(sb_empty), 32'd1);
        bus_q.delete(); cw_q.delete();
        hold_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Normal operation after reset.
        start_load(32'hF000_0004, 4'hF, 1'b0, 1'b0);
        finish_load("post_rst_unc", 32'h1234_5678, 1);
        do_store(32'h0000_0500, 4'h3, 32'hE000_0500, 1'b1);
        wait_empty("post_rst_store", 40);

        repeat (3) @(posedge clk); #1;
        check("bus_q_left", 32'(bus_q.size()), 32'd0);
        check("cw_q_left", 32'(cw_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
